// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions
// and the hex-to-segment lookup table (bit 0 = a ... bit 6 = g).
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble plus decimal point to active-high 8-bit segment
// pattern (seg[6:0] = g..a, seg[7] = dp).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    // Table lookup for a..g, decimal point passed straight through
    always_comb begin
        pattern               = 8'h00;
        pattern[SEG_G:SEG_A]  = HEX_SEG[nibble];
        pattern[SEG_DP]       = dp;
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scan driver with guard interval, blanking and frame
// strobe. Define SEVEN_SEG_BLINK_EN to build the single-digit blink cursor.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 1024,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*DIGITS-1:0]        value,
    input  logic [DIGITS-1:0]          dp,
    input  logic [DIGITS-1:0]          blank,
    input  logic [$clog2(DIGITS):0]    sel,
    output logic [7:0]                 seg,
    output logic [DIGITS-1:0]          anode,
    output logic                       frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int SEL_W = IDX_W + 1;
    localparam int P_W   = $clog2(SLOT_CYCLES);
    localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [7:0]        SEG_OFF   = {8{POL}};
    localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{POL}};

    logic [P_W-1:0]    p_r;
    logic [IDX_W-1:0]  idx_r;
    logic [7:0]        seg_r;
    logic [DIGITS-1:0] anode_r;
    logic              frame_tick_r;

    logic              load_s;
    logic              slot_end_s;
    logic              frame_end_s;
    logic              blink_hide_s;
    logic [3:0]        nibble_s;
    logic [7:0]        pattern_s;
    logic [DIGITS-1:0] onehot_s;

    assign load_s      = (p_r == P_W'(GUARD - 1));
    assign slot_end_s  = (p_r == P_W'(SLOT_CYCLES - 1));
    assign frame_end_s = slot_end_s && (idx_r == IDX_W'(DIGITS - 1));
    assign nibble_s    = value[{idx_r, 2'b00} +: 4];

    seven_seg_decode u_decode (
        .nibble  (nibble_s),
        .dp      (dp[idx_r]),
        .pattern (pattern_s)
    );

    // One-hot enable for the digit currently being scanned
    always_comb begin
        onehot_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_r;
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] frame_cnt_r;
    logic            ph_r;

    // Blink phase toggles after BLINK_FRAMES completed frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= {BF_W{1'b0}};
            ph_r        <= 1'b1;
        end else if (frame_end_s) begin
            if (frame_cnt_r == BF_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r <= {BF_W{1'b0}};
                ph_r        <= ~ph_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + {{(BF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign blink_hide_s = (sel == SEL_W'(idx_r)) && !ph_r;
`else
    logic unused_sel_s;
    assign unused_sel_s = ^sel;
    assign blink_hide_s = 1'b0;
`endif

    // Slot position and digit index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r   <= {P_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (slot_end_s) begin
            p_r   <= {P_W{1'b0}};
            idx_r <= frame_end_s ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            p_r   <= p_r + {{(P_W-1){1'b0}}, 1'b1};
        end
    end

    // Output registers: seg only reloads after the guard, while anodes are off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            anode_r      <= ANODE_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= frame_end_s;
            if (slot_end_s) begin
                anode_r <= ANODE_OFF;
            end else if (load_s) begin
                seg_r   <= pattern_s ^ SEG_OFF;
                anode_r <= (blank[idx_r] || blink_hide_s) ? ANODE_OFF : (onehot_s ^ ANODE_OFF);
            end
        end
    end

    assign seg        = seg_r;
    assign anode      = anode_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed vector table, multi-cycle
// corner sequences, then randomized inputs against a time-based reference model.
module tb_seven_seg_scan;

    localparam int D  = 4;
    localparam int S  = 8;
    localparam int G  = 2;
    localparam int BF = 2;
`ifdef SEVEN_SEG_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [2:0]  sel;
    logic [7:0]  seg;
    logic [3:0]  anode;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    seven_seg_scan #(
        .DIGITS(D), .SLOT_CYCLES(S), .GUARD(G), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .sel(sel),
        .seg(seg), .anode(anode), .frame_tick(frame_tick)
    );

    // Reference model: everything derives from t, the number of edges since reset
    int         m_t;
    logic [7:0] m_seg;
    logic [3:0] m_anode;
    logic       m_tick;

    function automatic int digit_of(int t);
        return (t / S) % D;
    endfunction

    function automatic logic [3:0] lit_anode(int t, logic [3:0] bl, logic [2:0] s);
        int  digit   = digit_of(t);
        bit  visible = ((t / (D * S)) / BF) % 2 == 0;
        if (bl[digit] || (BLINK_EN && int'(s) == digit && !visible))
            return 4'b0000;
        return 4'b0001 << digit;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t     <= 0;
            m_seg   <= 8'h00;
            m_anode <= 4'b0000;
            m_tick  <= 1'b0;
        end else begin
            m_t    <= m_t + 1;
            m_tick <= ((m_t + 1) % (D * S)) == 0;
            if (m_t % S == G - 1) begin
                m_seg   <= {dp[digit_of(m_t)], hex_tab[value[digit_of(m_t) * 4 +: 4]]};
                m_anode <= lit_anode(m_t, blank, sel);
            end else if (m_t % S == S - 1) begin
                m_anode <= 4'b0000;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic edges(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        int          n_edges;
        logic [3:0]  exp_anode;
        logic [7:0]  exp_seg;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        int ticks;
        logic [3:0] exp_blink;

        vecs[0]  = '{16'h1234, 4'b0000, 4'b0000,  1, 4'b0000, 8'h00};
        vecs[1]  = '{16'h1234, 4'b0000, 4'b0000,  2, 4'b0001, 8'h66};
        vecs[2]  = '{16'h1234, 4'b0000, 4'b0000,  7, 4'b0001, 8'h66};
        vecs[3]  = '{16'h1234, 4'b0000, 4'b0000,  8, 4'b0000, 8'h66};
        vecs[4]  = '{16'h1234, 4'b0000, 4'b0000, 10, 4'b0010, 8'h4F};
        vecs[5]  = '{16'h1234, 4'b0000, 4'b0000, 18, 4'b0100, 8'h5B};
        vecs[6]  = '{16'h1234, 4'b0000, 4'b0000, 26, 4'b1000, 8'h06};
        vecs[7]  = '{16'h1234, 4'b0000, 4'b0000, 34, 4'b0001, 8'h66};
        vecs[8]  = '{16'h1234, 4'b0000, 4'b0100, 18, 4'b0000, 8'h5B};
        vecs[9]  = '{16'h1234, 4'b0000, 4'b0100, 26, 4'b1000, 8'h06};
        vecs[10] = '{16'hF000, 4'b1000, 4'b0000, 26, 4'b1000, 8'hF1};
        vecs[11] = '{16'h89E0, 4'b0101, 4'b0000,  2, 4'b0001, 8'hBF};
        vecs[12] = '{16'h89E0, 4'b0101, 4'b0000, 10, 4'b0010, 8'h79};
        vecs[13] = '{16'h89E0, 4'b0101, 4'b0000, 18, 4'b0100, 8'hEF};
        vecs[14] = '{16'h89E0, 4'b0101, 4'b0000, 26, 4'b1000, 8'h7F};
        vecs[15] = '{16'hABCD, 4'b0000, 4'b0000,  2, 4'b0001, 8'h5E};
        vecs[16] = '{16'hABCD, 4'b0000, 4'b0000, 10, 4'b0010, 8'h39};
        vecs[17] = '{16'hABCD, 4'b0000, 4'b0000, 18, 4'b0100, 8'h7C};
        vecs[18] = '{16'hABCD, 4'b0000, 4'b0000, 26, 4'b1000, 8'h77};
        vecs[19] = '{16'h7650, 4'b0000, 4'b0000, 10, 4'b0010, 8'h6D};
        vecs[20] = '{16'h7650, 4'b0000, 4'b0000, 18, 4'b0100, 8'h7D};
        vecs[21] = '{16'h7650, 4'b0000, 4'b0000, 26, 4'b1000, 8'h07};

        value = 16'h1234;
        dp    = 4'b0000;
        blank = 4'b0000;
        sel   = 3'd4;
        repeat (2) @(negedge clk);
        check("reset_anode", anode, 4'b0000);
        check("reset_seg", seg, 8'h00);
        check("reset_tick", frame_tick, 1'b0);

        for (int i = 0; i < NV; i++) begin
            value = vecs[i].value;
            dp    = vecs[i].dp;
            blank = vecs[i].blank;
            apply_reset();
            edges(vecs[i].n_edges);
            check($sformatf("vec%0d_anode", i), anode, vecs[i].exp_anode);
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
        end

        // frame strobe position and rate
        value = 16'h1234; dp = 4'b0000; blank = 4'b0000;
        apply_reset();
        edges(31);
        check("tick_before", frame_tick, 1'b0);
        edges(1);
        check("tick_at32", frame_tick, 1'b1);
        edges(1);
        check("tick_after", frame_tick, 1'b0);
        ticks = 0;
        for (int c = 0; c < 64; c++) begin
            edges(1);
            ticks += int'(frame_tick);
        end
        check("tick_count", ticks, 2);

        // asynchronous reset in the middle of digit 2's slot
        apply_reset();
        edges(18);
        check("pre_rst_anode", anode, 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("async_anode", anode, 4'b0000);
        check("async_seg", seg, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        check("restart_guard", anode, 4'b0000);
        edges(1);
        check("restart_anode", anode, 4'b0001);
        check("restart_seg", seg, 8'h66);

        // blink cursor on digit 1
        sel = 3'd1;
        apply_reset();
        edges(10);
        for (int f = 0; f < 8; f++) begin
            if (f > 0) edges(32);
            exp_blink = (!BLINK_EN || (f % 4) < 2) ? 4'b0010 : 4'b0000;
            check($sformatf("blink_f%0d", f), anode, exp_blink);
        end
        sel = 3'd4;

        // randomized inputs and occasional resets against the reference model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            check("model", {19'd0, frame_tick, anode, seg}, {19'd0, m_tick, m_anode, m_seg});
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if ($urandom_range(0, 19) == 0) value = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dp    = 4'($urandom);
            if ($urandom_range(0, 59) == 0) blank = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 99) == 0) sel   = 3'($urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
